pat192_sched: RTL and testbench
===============================

PAT192_SCHED -- requirements
Module: pat192_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port enable, input, 1 bit: run request; level-sensitive.
REQ-004 SHALL have port burst_len, input, 8 bits: words per burst; 0 = continuous.
REQ-005 SHALL have port gap_len, input, 8 bits: idle cycles between bursts.
REQ-006 SHALL have port ts_period, input, 8 bits: timestamp-word spacing; 0 = no timestamps.
REQ-007 SHALL have port full, input, 1 bit: downstream 192-bit FIFO full.
REQ-008 SHALL have port push, output, 1 bit: word transfer strobe.
REQ-009 SHALL have port data, output, 192 bits: pattern word.
REQ-010 SHALL have port sendtime, output, 1 bit: current word carries a timestamp.
REQ-011 SHALL have port sent_cnt, output, 32 bits: total words pushed since reset, wrapping.
REQ-012 SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, RUN, GAP.
REQ-014 SHALL go IDLE->RUN on the edge where enable=1, latching burst_len, gap_len and ts_period; configuration SHALL be held until the next IDLE->RUN entry.
REQ-015 SHALL drive push combinationally as (state==RUN) & !full; a transfer occurs exactly when push=1.
REQ-016 SHALL compose data as 16 lanes of 12 bits, lane k at bits [12k+11:12k], with lane k = 16*seq + k mod 4096; seq is a 12-bit word index.
REQ-017 SHALL increment seq by 1 per transfer, wrapping 255->0, so lane 0 of consecutive words is always a multiple of 16.
REQ-018 SHALL assert sendtime for word index w when ts_period!=0 and (w mod ts_period)==ts_period-1; w counts transfers since the latest IDLE->RUN entry.
REQ-019 SHALL, when sendtime=1, drive data[31:0] from a free-running 32-bit cycle counter in the push cycle and data[35:32]=0; lanes 3..15 stay per REQ-016.
REQ-020 SHALL, in RUN with burst_len!=0, count transfers and, on the transfer completing burst_len words, go to GAP when gap_len!=0 or stay in RUN with the count restarted when gap_len==0.
REQ-021 SHALL hold GAP for exactly gap_len cycles, then return to RUN; push=0 throughout GAP.
REQ-022 SHALL not count stalled cycles (full=1 in RUN) toward the burst; the burst length counts transfers only.
REQ-023 SHALL, on enable=0, go to IDLE at the next edge from RUN or GAP; a transfer in that same cycle still completes; seq, sent_cnt and the cycle counter are retained.
REQ-024 SHALL increment sent_cnt once per transfer, wrapping at 2^32.

Reset
REQ-025 SHALL on reset clear state to IDLE, seq, w, the burst/gap counters, the cycle counter, sent_cnt and latched configuration to 0; push=0, sendtime=0, busy=0.
REQ-026 SHALL take effect immediately on reset assertion mid-burst, mid-gap or mid-stall, with no word pushed while reset=1.

Structure
REQ-027 SHALL place lane width 12, lane count 16, word width 192 and the state encoding in shared package pat192_pkg.
REQ-028 SHALL put burst/gap pacing in one sub-module pat192_pace (inputs: latched lengths, transfer strobe; outputs: burst_done, gap_active).

Verification
REQ-029 SHALL cover: reset, enable=1, burst_len=0, ts_period=0, full=0 -> push every cycle from the cycle after enable; word 0 lane0=0x000, lane15=0x00F; word 1 lane0=0x010.
REQ-030 SHALL cover: burst_len=4, gap_len=3 -> push pattern 1111000 repeating; sent_cnt=8 after two bursts.
REQ-031 SHALL cover: ts_period=4 -> sendtime on words 3, 7, 11; data[31:0] equals the cycle counter at push; data[35:32]=0.
REQ-032 SHALL cover: full=1 for 5 cycles mid-burst (burst_len=4) -> no push, seq frozen, burst resumes and completes with exactly 4 transfers.
REQ-033 SHALL cover: run 260 words -> seq wraps, word 256 lane0=0x000 following word 255 lane15=0xFFF.
REQ-034 SHALL cover: reset asserted during GAP -> outputs at reset values in the same cycle; re-enable restarts at lane0=0x000.

Source files
------------

// File: rtl/pat192_pkg.sv
// pat192_pkg: shared lane geometry, FSM encoding and lane value helper
package pat192_pkg;
  localparam int LANE_W = 12;
  localparam int LANES = 16;
  localparam int WORD_W = LANE_W * LANES;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_GAP = 2'd2;
  function automatic logic [LANE_W-1:0] lane_val(input logic [11:0] seq, input logic [3:0] k);
    return seq * 12'd16 + {8'd0, k};
  endfunction
endpackage

// File: rtl/pat192_pace.sv
// pat192_pace: burst word counting and gap timing; gap_active means more gap cycles remain after this one
module pat192_pace (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       xfer,
  input  logic [7:0] burst_len,
  input  logic [7:0] gap_len,
  output logic       burst_done,
  output logic       gap_active
);
  logic [7:0] bcnt_q, gcnt_q;
  assign burst_done = xfer && burst_len != 8'd0 && bcnt_q == burst_len - 8'd1;
  assign gap_active = gcnt_q != 8'd0;
  // burst counter advances on transfers only; gap counter loads on burst end and drains per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt_q <= '0;
      gcnt_q <= '0;
    end else if (clr) begin
      bcnt_q <= '0;
      gcnt_q <= '0;
    end else begin
      if (xfer) bcnt_q <= burst_done ? 8'd0 : bcnt_q + 8'd1;
      gcnt_q <= (burst_done && gap_len != 8'd0) ? gap_len - 8'd1 : gap_active ? gcnt_q - 8'd1 : gcnt_q;
    end
  end
endmodule

// File: rtl/pat192_sched.sv
// pat192_sched: paced 192-bit test pattern generator with optional timestamp words
module pat192_sched
  import pat192_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [7:0]        burst_len,
  input  logic [7:0]        gap_len,
  input  logic [7:0]        ts_period,
  input  logic              full,
  output logic              push,
  output logic [WORD_W-1:0] data,
  output logic              sendtime,
  output logic [31:0]       sent_cnt,
  output logic              busy
);
  logic [1:0] state_q, state_d;
  logic [7:0] blen_q, glen_q, tsp_q, ts_cnt_q;
  logic [11:0] seq_q;
  logic [31:0] cyc_q, sent_q;
  logic start, xfer, ts_hit, burst_done, gap_active;
  assign start = state_q == S_IDLE && enable;
  assign xfer = state_q == S_RUN && !full;
  assign push = xfer;
  assign ts_hit = tsp_q != 8'd0 && ts_cnt_q == tsp_q - 8'd1;
  assign sendtime = state_q == S_RUN && ts_hit;
  assign busy = state_q != S_IDLE;
  assign sent_cnt = sent_q;
  pat192_pace u_pace (
    .clk(clk),
    .reset(reset),
    .clr(start),
    .xfer(xfer),
    .burst_len(blen_q),
    .gap_len(glen_q),
    .burst_done(burst_done),
    .gap_active(gap_active)
  );
  // next state: enable low always returns to IDLE; RUN drops into GAP only when a gap is configured
  always_comb begin
    state_d = state_q == S_IDLE ? (enable ? S_RUN : S_IDLE) :
              !enable ? S_IDLE :
              state_q == S_RUN ? ((burst_done && glen_q != 8'd0) ? S_GAP : S_RUN) :
              gap_active ? S_GAP : S_RUN;
  end
  // lane pattern from seq, with the low 36 bits replaced by the cycle count on timestamp words
  always_comb begin
    data = '0;
    for (int k = 0; k < LANES; k++) data[k*LANE_W +: LANE_W] = lane_val(seq_q, 4'(k));
    if (sendtime) data[35:0] = {4'd0, cyc_q};
  end
  // state, latched config, word index, timestamp phase and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      blen_q <= '0;
      glen_q <= '0;
      tsp_q <= '0;
      ts_cnt_q <= '0;
      seq_q <= '0;
      cyc_q <= '0;
      sent_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_q + 32'd1;
      if (start) begin
        blen_q <= burst_len;
        glen_q <= gap_len;
        tsp_q <= ts_period;
      end
      if (start) ts_cnt_q <= '0;
      else if (xfer) ts_cnt_q <= ts_hit ? 8'd0 : ts_cnt_q + 8'd1;
      if (xfer) begin
        seq_q <= seq_q == 12'd255 ? 12'd0 : seq_q + 12'd1;
        sent_q <= sent_q + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_pat192_sched.sv
// tb_pat192_sched: randomized scoreboard bench against a transfer-count reference model
module tb_pat192_sched;
  localparam int M_IDLE = 0, M_RUN = 1, M_GAP = 2;
  logic clk = 0, reset = 1, enable = 0, full = 0;
  logic [7:0] burst_len = 0, gap_len = 0, ts_period = 0;
  logic push, sendtime, busy;
  logic [191:0] data;
  logic [31:0] sent_cnt;
  int total = 0, bad = 0;
  typedef struct {logic [191:0] d; logic st; logic [31:0] cnt;} word_t;
  word_t wq[$];
  logic [1:0] pq[$];
  bit chk_en = 0;
  int m_state, m_n, m_w, m_bc, m_gap, c_blen, c_glen, c_ts;
  int unsigned m_cyc;

  pat192_sched dut (
    .clk(clk), .reset(reset), .enable(enable), .burst_len(burst_len), .gap_len(gap_len),
    .ts_period(ts_period), .full(full), .push(push), .data(data), .sendtime(sendtime),
    .sent_cnt(sent_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [191:0] a, input logic [191:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  function automatic void model_reset();
    m_state = M_IDLE; m_n = 0; m_w = 0; m_bc = 0; m_gap = 0; m_cyc = 0;
    c_blen = 0; c_glen = 0; c_ts = 0;
  endfunction

  function automatic word_t mk();
    word_t r;
    r.d = '0;
    for (int k = 0; k < 16; k++) begin
      int lane;
      lane = (16 * (m_n % 256) + k) % 4096;
      r.d[12*k +: 12] = lane[11:0];
    end
    r.st = c_ts != 0 && (m_w % c_ts) == c_ts - 1;
    if (r.st) r.d[35:0] = {4'h0, m_cyc};
    r.cnt = 32'(m_n);
    return r;
  endfunction

  task automatic cfg(input int b, input int g, input int t);
    burst_len = 8'(b); gap_len = 8'(g); ts_period = 8'(t);
  endtask

  task automatic cycle(input bit en, input bit f);
    bit ep;
    enable = en; full = f;
    ep = m_state == M_RUN && !f;
    pq.push_back({ep, m_state != M_IDLE});
    if (ep) wq.push_back(mk());
    @(posedge clk); #1;
    m_cyc++;
    if (ep) begin m_n++; m_w++; m_bc++; end
    if (m_state == M_IDLE) begin
      if (en) begin
        m_state = M_RUN; m_w = 0; m_bc = 0;
        c_blen = burst_len; c_glen = gap_len; c_ts = ts_period;
      end
    end else if (!en) m_state = M_IDLE;
    else if (m_state == M_RUN) begin
      if (c_blen != 0 && m_bc == c_blen) begin
        m_bc = 0;
        if (c_glen != 0) begin m_state = M_GAP; m_gap = c_glen; end
      end
    end else begin
      m_gap--;
      if (m_gap == 0) m_state = M_RUN;
    end
  endtask

  task automatic do_reset();
    chk_en = 0;
    #2 reset = 1;
    #1;
    chk("rst_push", push, 0); chk("rst_busy", busy, 0);
    chk("rst_sendtime", sendtime, 0); chk("rst_sent_cnt", sent_cnt, 0);
    repeat (3) begin @(negedge clk); chk("rst_hold_push", push, 0); end
    @(posedge clk); #1 reset = 0;
    model_reset();
    chk_en = 1;
  endtask

  always @(negedge clk) begin : mon
    logic [1:0] e;
    word_t w;
    if (chk_en) begin
      if (pq.size() == 0) begin
        total++; bad++;
        $display("FAIL sched: got no expectation want one per cycle");
      end else begin
        e = pq.pop_front();
        chk("push", push, e[1]);
        chk("busy", busy, e[0]);
        if (e[1]) begin
          w = wq.pop_front();
          if (push) begin
            chk("data", data, w.d);
            chk("sendtime", sendtime, w.st);
            chk("sent_cnt", sent_cnt, w.cnt);
          end
        end
      end
    end
  end

  initial begin
    int n0;
    bit ok;
    #2;
    chk("init_push", push, 0); chk("init_busy", busy, 0);
    chk("init_sendtime", sendtime, 0); chk("init_sent_cnt", sent_cnt, 0);
    @(posedge clk); #1 reset = 0;
    model_reset();
    chk_en = 1;
    cfg(0, 0, 0);
    repeat (20) cycle(1, 0);
    repeat (2) cycle(0, 0);
    n0 = m_n;
    cfg(4, 3, 0);
    repeat (15) cycle(1, 0);
    chk("sent_cnt_2bursts", sent_cnt, 32'(n0 + 8));
    cfg(1, 1, 1);
    repeat (7) cycle(1, 0);
    repeat (2) cycle(0, 0);
    cfg(0, 0, 4);
    repeat (16) cycle(1, 0);
    repeat (2) cycle(0, 0);
    cfg(4, 2, 0);
    repeat (3) cycle(1, 0);
    repeat (5) cycle(1, 1);
    repeat (8) cycle(1, 0);
    repeat (2) cycle(0, 0);
    cfg(0, 0, 0);
    repeat (262) cycle(1, 0);
    cycle(0, 0);
    repeat (12) begin
      cfg($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 5));
      repeat (60) begin
        cycle($urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) cfg($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 5));
      end
      cycle(0, 0);
    end
    cfg(2, 5, 3);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      cycle(1, 0);
      ok = m_state == M_GAP;
    end
    chk("reach_gap", ok, 1);
    cycle(1, 0);
    do_reset();
    cfg(0, 0, 0);
    repeat (5) cycle(1, 0);
    cfg(4, 0, 0);
    repeat (2) cycle(1, 0);
    repeat (2) cycle(1, 1);
    do_reset();
    repeat (6) cycle(1, 0);
    repeat (2) cycle(0, 0);
    @(negedge clk);
    chk_en = 0;
    chk("drain", pq.size() + wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
